// File: rtl/counter_display_pkg.sv
// counter_display_pkg
//  Shared constants and helpers for the counter/7-segment display block.
//  SEG_BLANK     : all segments off (active-low), decimal point off.
//  hex_to_sseg() : 4-bit nibble -> {dp,g,f,e,d,c,b,a}, active-low, dp held off.
package counter_display_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // The decimal point is never driven, so bit 7 is always 1 (off).
  function automatic logic [7:0] hex_to_sseg(input logic [3:0] nibble);
    logic [6:0] pat;
    case (nibble)
      4'h0:    pat = 7'h40;
      4'h1:    pat = 7'h79;
      4'h2:    pat = 7'h24;
      4'h3:    pat = 7'h30;
      4'h4:    pat = 7'h19;
      4'h5:    pat = 7'h12;
      4'h6:    pat = 7'h02;
      4'h7:    pat = 7'h78;
      4'h8:    pat = 7'h00;
      4'h9:    pat = 7'h10;
      4'hA:    pat = 7'h08;
      4'hB:    pat = 7'h03;
      4'hC:    pat = 7'h46;
      4'hD:    pat = 7'h21;
      4'hE:    pat = 7'h06;
      4'hF:    pat = 7'h0E;
      default: pat = SEG_BLANK[6:0];
    endcase
    return {1'b1, pat};
  endfunction

endpackage

// File: rtl/tick_gen.sv
// tick_gen
//  Free-running prescaler 0..DIV-1; tick is high for the single cycle in
//  which the prescaler sits at DIV-1. DIV=1 gives a permanently high tick.
//  Ports:
//   clock in  system clock
//   reset in  synchronous, active-high
//   tick  out one-cycle strobe every DIV cycles (combinational from state)
module tick_gen #(
  parameter int DIV = 2
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CW'(DIV - 1));

  // NOTE: every signal assigned in always_comb gets a value on every path,
  // otherwise synthesis infers a latch.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (tick) cnt_d = '0;
  end

  // NOTE: state registers use non-blocking assignments so all flops sample
  // their inputs from the same pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/counter_display.sv
// counter_display
//  Prescaled up/down counter (wrap or saturate) with synchronous load and a
//  terminal-count pulse, shown in hex on a multiplexed active-low 7-seg display.
//  Ports:
//   clock       in  system clock
//   reset       in  synchronous, active-high
//   enable      in  count on step tick when high
//   up_down     in  1 = increment, 0 = decrement
//   load        in  synchronous load of load_value (highest priority)
//   load_value  in  WIDTH-bit load value
//   count       out current count
//   tc          out one-cycle pulse after a step attempted at the limit
//   seg         out {dp,g,f,e,d,c,b,a}, active-low
//   an          out active-low one-hot digit enables
module counter_display
  import counter_display_pkg::*;
#(
  parameter int CLK_HZ   = 100_000_000,
  parameter int TICK_HZ  = 1,
  parameter int SCAN_HZ  = 1000,
  parameter int WIDTH    = 8,
  parameter int DIGITS   = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              up_down,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_value,
  output logic [WIDTH-1:0]  count,
  output logic              tc,
  output logic [7:0]        seg,
  output logic [DIGITS-1:0] an
);

  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int SDIV  = CLK_HZ / SCAN_HZ;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PADW  = 4 * DIGITS;

  logic step_tick, scan_tick;

  tick_gen #(.DIV(DIV)) u_step_tick (
    .clock (clock),
    .reset (reset),
    .tick  (step_tick)
  );

  tick_gen #(.DIV(SDIV)) u_scan_tick (
    .clock (clock),
    .reset (reset),
    .tick  (scan_tick)
  );

  // ---------------------------------------------------------------- counter
  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             at_limit;

  // The limit depends on direction: all-ones going up, zero going down.
  assign at_limit = up_down ? (count_q == '1) : (count_q == '0);

  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    if (load) begin
      count_d = load_value;
    end else if (enable && step_tick) begin
      // tc flags the attempt at the limit in both modes; only the resulting
      // count differs (natural modulo wrap vs hold).
      tc_d = at_limit;
      if (!(at_limit && SATURATE)) begin
        count_d = up_down ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;

  // -------------------------------------------------------------- digit mux
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [PADW-1:0]  count_pad;
  logic [3:0]       nibble;

  always_comb begin
    idx_d = idx_q;
    if (scan_tick) begin
      idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) idx_q <= '0;
    else       idx_q <= idx_d;
  end

  // Digits above WIDTH read as zero; seg and an both derive from registered
  // state, so they switch on the same edge.
  assign count_pad = PADW'(count_q);
  assign nibble    = count_pad[{idx_q, 2'b00} +: 4];
  assign seg       = hex_to_sseg(nibble);
  assign an        = ~(DIGITS'(1) << idx_q);

endmodule

// File: tb/tb_counter_display.sv
// tb_counter_display
//  Drives two instances (wrap and saturate) from shared stimulus. A bench-side
//  reference model predicts every cycle; predictions are queued as stimulus is
//  applied and popped for comparison when the DUT outputs are sampled.
module tb_counter_display;

  logic       clk = 1'b0;
  logic       reset, enable, up_down, load;
  logic [7:0] load_value;
  logic [7:0] count_w, count_s, seg_w, seg_s;
  logic       tc_w, tc_s;
  logic [3:0] an_w, an_s;

  always #5 clk = ~clk;

  counter_display #(
    .CLK_HZ(16), .TICK_HZ(1), .SCAN_HZ(4), .WIDTH(8), .DIGITS(4), .SATURATE(1'b0)
  ) u_wrap (
    .clock(clk), .reset(reset), .enable(enable), .up_down(up_down),
    .load(load), .load_value(load_value),
    .count(count_w), .tc(tc_w), .seg(seg_w), .an(an_w)
  );

  counter_display #(
    .CLK_HZ(16), .TICK_HZ(1), .SCAN_HZ(4), .WIDTH(8), .DIGITS(4), .SATURATE(1'b1)
  ) u_sat (
    .clock(clk), .reset(reset), .enable(enable), .up_down(up_down),
    .load(load), .load_value(load_value),
    .count(count_s), .tc(tc_s), .seg(seg_s), .an(an_s)
  );

  // Independent copy of the hex table, already in {dp,g..a} active-low form.
  localparam logic [7:0] SEG_TBL [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  typedef struct {
    logic [7:0] cnt_w, cnt_s, seg_w, seg_s;
    logic       tc_w, tc_s;
    logic [3:0] an;
  } exp_t;

  exp_t exp_q[$];

  int n_pass = 0;
  int n_total = 0;

  // reference model state (values as of the last clock edge)
  int presc_m, scan_m, idx_m, cw_m, cs_m;
  bit tcw_m, tcs_m;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, req, $time);
  endtask

  function automatic void step_cnt(input int c, input bit sat, input bit stp,
                                   output int nc, output bit ntc);
    ntc = 1'b0;
    nc  = c;
    if (load) nc = int'(load_value);
    else if (enable && stp) begin
      if (up_down) begin
        if (c == 255) begin ntc = 1'b1; nc = sat ? 255 : 0; end
        else nc = c + 1;
      end else begin
        if (c == 0) begin ntc = 1'b1; nc = sat ? 0 : 255; end
        else nc = c - 1;
      end
    end
  endfunction

  function automatic logic [7:0] seg_of(input int c, input int idx);
    return SEG_TBL[(c >> (4 * idx)) & 15];
  endfunction

  task automatic model_step();
    bit stp, stk;
    int ncw, ncs;
    bit ntw, nts;
    if (reset) begin
      presc_m = 0; scan_m = 0; idx_m = 0;
      cw_m = 0; cs_m = 0; tcw_m = 0; tcs_m = 0;
    end else begin
      stp = (presc_m == 15);
      stk = (scan_m == 3);
      presc_m = stp ? 0 : presc_m + 1;
      scan_m  = stk ? 0 : scan_m + 1;
      if (stk) idx_m = (idx_m + 1) % 4;
      step_cnt(cw_m, 1'b0, stp, ncw, ntw);
      step_cnt(cs_m, 1'b1, stp, ncs, nts);
      cw_m = ncw; cs_m = ncs; tcw_m = ntw; tcs_m = nts;
    end
  endtask

  // One clock: update the model at the edge, queue its prediction, then pop
  // and compare against the DUTs on the falling edge.
  task automatic cycle();
    exp_t e;
    exp_t g;
    @(posedge clk);
    model_step();
    e.cnt_w = 8'(cw_m);
    e.cnt_s = 8'(cs_m);
    e.tc_w  = tcw_m;
    e.tc_s  = tcs_m;
    e.an    = 4'hF;
    e.an[idx_m] = 1'b0;
    e.seg_w = seg_of(cw_m, idx_m);
    e.seg_s = seg_of(cs_m, idx_m);
    exp_q.push_back(e);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      g = exp_q.pop_front();
      check("count_wrap", 32'(count_w), 32'(g.cnt_w));
      check("count_sat",  32'(count_s), 32'(g.cnt_s));
      check("tc_wrap",    32'(tc_w),    32'(g.tc_w));
      check("tc_sat",     32'(tc_s),    32'(g.tc_s));
      check("an_wrap",    32'(an_w),    32'(g.an));
      check("an_sat",     32'(an_s),    32'(g.an));
      check("seg_wrap",   32'(seg_w),   32'(g.seg_w));
      check("seg_sat",    32'(seg_s),   32'(g.seg_s));
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_load(input logic [7:0] v);
    load = 1'b1;
    load_value = v;
    cycle();
    load = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; up_down = 1'b1; load = 1'b0; load_value = 8'h00;
    presc_m = 0; scan_m = 0; idx_m = 0; cw_m = 0; cs_m = 0; tcw_m = 0; tcs_m = 0;

    // reset state
    run(2);
    check("reset_seg", 32'(seg_w), 32'hC0);
    check("reset_an",  32'(an_w),  32'hE);

    // count up from reset: steps land on edges 16/32/48/64
    reset = 1'b0; enable = 1'b1; up_down = 1'b1;
    run(64);
    check("up_after_64", 32'(count_w), 32'h04);

    // wrap at top (and hold in saturate mode)
    do_load(8'hFE);
    run(48);
    check("wrap_top", 32'(count_w), 32'h01);
    check("sat_top",  32'(count_s), 32'hFF);

    // underflow going down, then turn around
    do_load(8'h00);
    up_down = 1'b0;
    run(40);
    up_down = 1'b1;
    run(20);

    // load coinciding with a step tick wins and clears tc
    for (int i = 0; i < 16 && presc_m != 15; i++) cycle();
    load = 1'b1; load_value = 8'h5A;
    cycle();
    load = 1'b0;
    check("load_on_tick_cnt", 32'(count_w), 32'h5A);
    check("load_on_tick_tc",  32'(tc_w),    32'h0);

    // digit scan of a held value
    enable = 1'b0;
    do_load(8'h3C);
    run(16);

    // reset in the middle of a count period
    enable = 1'b1;
    do_load(8'h07);
    for (int i = 0; i < 16 && presc_m != 9; i++) cycle();
    reset = 1'b1;
    cycle();
    check("midrst_count", 32'(count_w), 32'h00);
    check("midrst_an",    32'(an_w),    32'hE);
    check("midrst_seg",   32'(seg_w),   32'hC0);
    check("midrst_tc",    32'(tc_w),    32'h0);
    reset = 1'b0;
    run(20);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
